// File: rtl/sys_bridge.sv
// sys_bridge: CPU data-port bridge to two TC timers plus an external irq.
// Define SYS_BRIDGE_EDGE_IRQ_EN for edge-latched PEND with write-1-to-clear.
`ifndef DEV_ADDR_WD
`define DEV_ADDR_WD 2
`endif
`ifndef WR_EN
`define WR_EN 1'b1
`endif
`ifndef WR_DIS
`define WR_DIS 1'b0
`endif

module sys_bridge #(
    parameter int ERRCNT_WD = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             pr_addr_i,
    input  logic                    pr_we_i,
    input  logic [31:0]             pr_wdata_i,
    output logic [31:0]             pr_rdata_o,
    output logic [5:0]              hwint_o,
    output logic                    tc0_we_o,
    output logic                    tc1_we_o,
    output logic [`DEV_ADDR_WD-1:0] tc0_add_o,
    output logic [`DEV_ADDR_WD-1:0] tc1_add_o,
    output logic [31:0]             tc0_dat_o,
    output logic [31:0]             tc1_dat_o,
    input  logic [31:0]             tc0_dat_i,
    input  logic [31:0]             tc1_dat_i,
    input  logic                    tc0_irq_i,
    input  logic                    tc1_irq_i,
    input  logic                    ext_irq_i
);

    localparam logic [ERRCNT_WD-1:0] ERR_MAX = {ERRCNT_WD{1'b1}};

    logic                 wr;
    logic                 dev_hit;
    logic                 sel_tc0;
    logic                 sel_tc1;
    logic                 sel_reg;
    logic                 sel_unm;
    logic [1:0]           reg_idx;
    logic [2:0]           irq;
    logic [2:0]           mask;
    logic [2:0]           pend;
    logic [ERRCNT_WD-1:0] errcnt;
    logic [31:0]          reg_rdata;
    logic                 unused_addr;

    assign wr      = (pr_we_i == `WR_EN);
    assign dev_hit = (pr_addr_i[31:8] == 24'h00007F);
    assign sel_tc0 = dev_hit && (pr_addr_i[7:4] == 4'h0);
    assign sel_tc1 = dev_hit && (pr_addr_i[7:4] == 4'h1);
    assign sel_reg = dev_hit && (pr_addr_i[7:4] == 4'h2);
    assign sel_unm = dev_hit && (pr_addr_i[7:4] > 4'h2);
    assign reg_idx = pr_addr_i[3:2];
    assign irq     = {ext_irq_i, tc1_irq_i, tc0_irq_i};

    assign unused_addr = ^pr_addr_i[1:0];

    assign tc0_we_o  = wr && sel_tc0;
    assign tc1_we_o  = wr && sel_tc1;
    assign tc0_add_o = pr_addr_i[`DEV_ADDR_WD+1:2];
    assign tc1_add_o = pr_addr_i[`DEV_ADDR_WD+1:2];
    assign tc0_dat_o = pr_wdata_i;
    assign tc1_dat_o = pr_wdata_i;

    assign hwint_o = {3'b000, pend & mask};

`ifdef SYS_BRIDGE_EDGE_IRQ_EN
    logic [2:0] irq_q;
    logic [2:0] pend_clr;

    assign pend_clr = (wr && sel_reg && reg_idx == 2'd0) ?
                      pr_wdata_i[2:0] : 3'b000;

    // a rise in the same cycle as a clear of that bit leaves it set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 3'b000;
            pend  <= 3'b000;
        end else begin
            irq_q <= irq;
            pend  <= (pend & ~pend_clr) | (irq & ~irq_q);
        end
    end
`else
    assign pend = irq;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask <= 3'b000;
        end else if (wr && sel_reg && reg_idx == 2'd1) begin
            mask <= pr_wdata_i[2:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            errcnt <= '0;
        end else if (wr && sel_reg && reg_idx == 2'd2) begin
            errcnt <= '0;
        end else if (sel_unm && errcnt != ERR_MAX) begin
            errcnt <= errcnt + 1'b1;
        end
    end

    always_comb begin
        reg_rdata = 32'h0;
        unique case (reg_idx)
            2'd0:    reg_rdata = {29'h0, pend};
            2'd1:    reg_rdata = {29'h0, mask};
            2'd2:    reg_rdata = 32'(errcnt);
            default: reg_rdata = 32'h0;
        endcase
    end

    always_comb begin
        pr_rdata_o = 32'h0;
        unique case (1'b1)
            sel_tc0: pr_rdata_o = tc0_dat_i;
            sel_tc1: pr_rdata_o = tc1_dat_i;
            sel_reg: pr_rdata_o = reg_rdata;
            default: pr_rdata_o = 32'h0;
        endcase
    end

endmodule
